uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. Each single-cycle `wr` pulse (driven by the receiver's `rx_done_tick`) pushes one byte (driven by `rx_dout`) into a circular buffer. Software-facing logic pops bytes with a `rd` pulse. The block tracks occupancy and keeps a sticky overrun flag for bytes dropped while the buffer is full.

## Interface

Parameters:
- `DBIT`, 8: data width in bits; matches the receiver's data width.
- `ADDR_W`, 4: address width; depth is `2**ADDR_W` entries (16 by default).

Ports:
- `clk` input 1: single system clock; all state updates on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset; clears all state immediately.
- `wr` input 1: write strobe, one cycle per byte.
- `w_data` input `DBIT`: byte sampled on a clock edge where `wr`=1.
- `rd` input 1: read/pop strobe; removes the head entry.
- `r_data` output `DBIT`: head entry, first-word-fall-through.
- `empty` output 1: asserted when the buffer holds 0 entries.
- `full` output 1: asserted when the buffer holds `2**ADDR_W` entries.
- `count` output `ADDR_W+1`: number of stored entries, from 0 to `2**ADDR_W`.
- `overrun` output 1: sticky; set when a write is dropped.
- `clr_overrun` input 1: clears `overrun`.

## Operation

Storage:
- Storage is a register array of `2**ADDR_W` x `DBIT` bits, with a write pointer `w_ptr` and a read pointer `r_ptr`, each `ADDR_W` bits wide.
- The array is not reset.
- Pointers wrap modulo `2**ADDR_W` by natural overflow.

Registered status:
- `count` is held in a register.
- `empty` = (`count`==0) and `full` = (`count`==`2**ADDR_W`). Both are decoded directly from the register with no extra latency.

Read data:
- `r_data` = `mem[r_ptr]`, a combinational read.
- `r_data` is valid only while `empty`=0. While `empty`=1 its value is don't-care, and the bench must not check it.

Per-edge action, decided on {`wr`, `rd`, `empty`, `full`}:
- `wr` only, not full: write `mem[w_ptr]`=`w_data`; `w_ptr`+1; `count`+1.
- `wr` only, full: byte dropped; pointers and `count` unchanged; `overrun` set to 1.
- `rd` only, not empty: `r_ptr`+1; `count`-1.
- `rd` only, empty: ignored; no state change, no flag.
- `wr`+`rd`, neither empty nor full: write and pop both occur; `count` unchanged.
- `wr`+`rd`, empty: write only; the read is ignored; `count` goes to 1.
- `wr`+`rd`, full: pop the head and write the new byte; `count` stays full; no overrun.

Overrun flag:
- `overrun` is cleared by `clr_overrun`=1.
- If a drop and `clr_overrun` occur in the same cycle, set wins and `overrun`=1.

Reset (`reset_n`=0, at any time including mid-transfer):
- `w_ptr`=0, `r_ptr`=0, `count`=0, `overrun`=0.
- As a result `empty`=1 and `full`=0.
- Stored contents are logically discarded.

## Timing

- All outputs are registered-state derived; none depends combinationally on `wr` or `rd`.
- Write latency: a `wr` at edge N makes the byte visible on `r_data` with `empty`=0 immediately after edge N, so it is observable in cycle N+1.
- Pop: after a `rd` at edge N, the next entry appears on `r_data` after edge N, or `empty`=1 if the popped entry was the last.
- Back-to-back `wr` on every cycle is supported; `rd` on every cycle is supported.
- Throughput is 1 write and 1 read per cycle.
- `wr` and `rd` are level-sampled per edge. A strobe held high for k cycles performs k operations.

## Test plan

- **Reset:** assert `reset_n`=0 mid-stream with `count`=5. Required:
  - Immediately, asynchronously: `count`=0, `empty`=1, `full`=0, `overrun`=0.
  - After release, write 0xA5 and it reads back 0xA5.
- **Single byte:** `wr` with 0x3C, then one idle cycle, then `rd`. Required:
  - `empty` falls the cycle after `wr`, and `r_data`=0x3C.
  - After the `rd` edge: `empty`=1 and `count`=0.
- **Fill and overrun:** write 0x00..0x0F (16 bytes). Required:
  - `full`=1 and `count`=16.
  - A 17th write of 0xFF is dropped and `overrun`=1.
  - 16 reads return 0x00..0x0F in order.
  - `overrun` stays 1 until `clr_overrun`.
- **Simultaneous operations:**
  - `wr`+`rd` at full: `count` stays 16, `overrun` stays 0, and the new byte appears as the last read.
  - `wr`+`rd` at empty: `count`=1 and `r_data`=`w_data`.
- **Wrap-around:** 40 writes interleaved with reads, keeping occupancy between 1 and 3. Required:
  - Data order preserved across pointer wrap.
  - `count` matches the reference model every cycle.
- **Read on empty, and clear/set race:**
  - `rd` with `empty`=1: no change to `count` or pointers.
  - A dropped write and `clr_overrun` in the same cycle: `overrun`=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side circular buffer placed after the UART receiver.
// Each wr pulse pushes one byte, and each rd pulse pops the head entry.
// r_data shows the head entry combinationally (first-word-fall-through).
// The block tracks occupancy in a count register and keeps a sticky
// overrun flag that records bytes dropped because the buffer was full.
//
// Ports:
//   clk          system clock; all state changes on its rising edge
//   reset_n      asynchronous, active-low reset
//   wr, w_data   write strobe and the byte to write
//   rd           pop strobe for the head entry
//   r_data       head entry; valid only while empty = 0
//   empty, full  occupancy status, decoded from count
//   count        number of stored entries, from 0 to 2**ADDR_W
//   overrun      sticky flag for a dropped write
//   clr_overrun  clears overrun; a drop in the same cycle takes priority
module uart_rx_fifo #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wr,
  input  logic [DBIT-1:0] w_data,
  input  logic            rd,
  output logic [DBIT-1:0] r_data,
  output logic            empty,
  output logic            full,
  output logic [ADDR_W:0] count,
  output logic            overrun,
  input  logic            clr_overrun
);

  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};

  logic [DBIT-1:0]   r_mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overrun;

  logic w_empty;
  logic w_full;
  logic w_do_wr;
  logic w_do_rd;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  // When the buffer is full, a write can still be accepted if a pop happens
  // on the same edge, because the pop frees the slot the write needs.
  // A read while the buffer is empty is always ignored.
  assign w_do_wr = wr & (~w_full | rd);
  assign w_do_rd = rd & ~w_empty;
  assign w_drop  = wr & w_full & ~rd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
      if (w_drop)           r_overrun <= 1'b1;
      else if (clr_overrun) r_overrun <= 1'b0;
    end
  end

  // The storage array has no reset; the pointers alone define which
  // entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr] <= w_data;
  end

  assign r_data  = r_mem[r_rptr];
  assign empty   = w_empty;
  assign full    = w_full;
  assign count   = r_count;
  assign overrun = r_overrun;

endmodule
